// File: rtl/sampling_pkg.sv
// Shared types and sizing helpers for the sample capture sequencer.
package sampling_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSkip,
        StCapture,
        StSerial,
        StFull
    } cap_state_e;

    // Number of SRAM words addressable with an aw-bit address.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Width of a channel index; at least one bit so NCH=1 still has a legal vector.
    function automatic int unsigned chan_idx_w(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/chan_serializer.sv
// Latches one NCH-channel conversion and emits its words on consecutive cycles,
// channel 0 first. valid/data are registered; done marks the last word. abort
// drops any remaining words.
module chan_serializer
    import sampling_pkg::*;
#(
    parameter int unsigned DW  = 16,
    parameter int unsigned NCH = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [NCH*DW-1:0] load_data,
    input  logic            abort,
    output logic            valid,
    output logic [DW-1:0]   data,
    output logic            done
);

    localparam int unsigned IdxW = chan_idx_w(NCH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCH - 1);

    logic [NCH*DW-1:0] shadow_q;
    logic [IdxW-1:0]   idx_q;
    logic              valid_q;
    logic [DW-1:0]     data_q;

    // Shift-out register: shadow holds the channels not yet presented on data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else if (abort) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
        end else if (load) begin
            shadow_q <= load_data >> DW;
            data_q   <= load_data[DW-1:0];
            idx_q    <= '0;
            valid_q  <= 1'b1;
        end else if (valid_q) begin
            if (idx_q == LastIdx) begin
                valid_q <= 1'b0;
                idx_q   <= '0;
            end else begin
                idx_q    <= idx_q + IdxW'(1);
                data_q   <= shadow_q[DW-1:0];
                shadow_q <= shadow_q >> DW;
            end
        end
    end

    // Output view of the serializer state.
    always_comb begin
        valid = valid_q;
        data  = data_q;
        done  = valid_q && (idx_q == LastIdx);
    end

endmodule

// File: rtl/sample_capture_ctrl.sv
// Capture sequencer between the ADC host and the sample SRAM. An arm edge
// enables the ADC, drops the first (stale) conversion, then writes NCH words
// per kept conversion to consecutive addresses until 2**AW words are stored.
// Optional build macro CAPTURE_AVG_EN: each write group is the truncated mean of
// 2**AVG_LOG2 kept conversions instead of a raw sample.
module sample_capture_ctrl
    import sampling_pkg::*;
#(
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 16,
    parameter int unsigned NCH = 1,
    parameter int unsigned DEC = 0
`ifdef CAPTURE_AVG_EN
    ,
    parameter int unsigned AVG_LOG2 = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              sample_valid,
    input  logic [NCH*DW-1:0] sample_data,
    output logic              adc_en,
    output logic              wen,
    output logic [AW-1:0]     waddr,
    output logic [DW-1:0]     wdata,
    output logic              full,
    output logic              busy,
    output logic              overrun,
    output logic [AW:0]       words
);

    localparam int unsigned Depth  = depth_of(AW);
    localparam logic [AW:0] DepthW = (AW+1)'(Depth);
    localparam logic [7:0]  DecMax = 8'(DEC);

    cap_state_e state_q, state_d;

    logic              arm_q;
    logic              arm_edge;
    logic [AW-1:0]     waddr_q;
    logic [AW:0]       words_q;
    logic [7:0]        dec_q;
    logic              overrun_q;
    logic              kept_conv;
    logic              group_ready;
    logic              load_req;
    logic [NCH*DW-1:0] load_data;
    logic              ser_valid;
    logic              ser_done;
    logic [DW-1:0]     ser_data;

    assign arm_edge  = arm & ~arm_q;
    assign kept_conv = sample_valid && (dec_q == 8'd0);
    assign load_req  = (state_q == StCapture) && kept_conv && group_ready;

`ifdef CAPTURE_AVG_EN
    localparam int unsigned AccW    = DW + AVG_LOG2;
    localparam logic [7:0]  AvgLast = 8'((32'd1 << AVG_LOG2) - 1);

    logic [AccW-1:0] acc_q   [NCH];
    logic [AccW-1:0] acc_sum [NCH];
    logic [7:0]      avg_cnt_q;

    assign group_ready = (avg_cnt_q == AvgLast);

    // Running sum including the conversion on sample_data; its mean feeds the serializer.
    always_comb begin
        load_data = '0;
        for (int c = 0; c < NCH; c++) begin
            acc_sum[c] = acc_q[c] + AccW'(sample_data[c*DW +: DW]);
            load_data[c*DW +: DW] = DW'(acc_sum[c] >> AVG_LOG2);
        end
    end

    // Accumulate kept conversions; restart after each write group and on arm.
    always_ff @(posedge clk) begin
        if (!rst || arm_edge) begin
            avg_cnt_q <= '0;
            for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
        end else if ((state_q == StCapture) && kept_conv) begin
            if (group_ready) begin
                avg_cnt_q <= '0;
                for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
            end else begin
                avg_cnt_q <= avg_cnt_q + 8'd1;
                for (int c = 0; c < NCH; c++) acc_q[c] <= acc_sum[c];
            end
        end
    end
`else
    assign group_ready = 1'b1;
    assign load_data   = sample_data;
`endif

    chan_serializer #(
        .DW  (DW),
        .NCH (NCH)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load_req && !arm_edge),
        .load_data (load_data),
        .abort     (arm_edge),
        .valid     (ser_valid),
        .data      (ser_data),
        .done      (ser_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state logic; an arm edge restarts from any state.
    always_comb begin
        state_d = state_q;
        if (arm_edge) begin
            state_d = StSkip;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StIdle;
                StSkip:    if (sample_valid) state_d = StCapture;
                StCapture: if (load_req) state_d = StSerial;
                StSerial:  if (ser_done) state_d = (words_q + (AW+1)'(1) == DepthW) ? StFull
                                                                                   : StCapture;
                StFull:    state_d = StFull;
                default:   state_d = StIdle;
            endcase
        end
    end

    // Arm edge detect, address/word counters, decimation and overrun tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            arm_q     <= 1'b0;
            waddr_q   <= '0;
            words_q   <= '0;
            dec_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            arm_q <= arm;
            if (arm_edge) begin
                waddr_q   <= '0;
                words_q   <= '0;
                dec_q     <= '0;
                overrun_q <= 1'b0;
            end else begin
                // waddr wraps to 0 after the last word, words saturates naturally at DEPTH.
                if (ser_valid) begin
                    waddr_q <= waddr_q + AW'(1);
                    words_q <= words_q + (AW+1)'(1);
                end
                if (sample_valid && (state_q == StCapture || state_q == StSerial)) begin
                    dec_q <= (dec_q == DecMax) ? 8'd0 : dec_q + 8'd1;
                end
                if (sample_valid && (state_q == StSerial)) overrun_q <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from state plus registered datapath values.
    always_comb begin
        adc_en  = (state_q == StSkip) || (state_q == StCapture) || (state_q == StSerial);
        busy    = adc_en;
        full    = (state_q == StFull);
        wen     = ser_valid;
        wdata   = ser_data;
        waddr   = waddr_q;
        words   = words_q;
        overrun = overrun_q;
    end

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Bench for sample_capture_ctrl: instance A (NCH=1, AW=4, DEC=0) and instance B
// (NCH=4, AW=4, DEC=2). Expected writes are queued as stimulus is driven and
// popped by a monitor whenever the DUT strobes wen.
module tb_sample_capture_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              arm_a, sv_a;
    logic [DW-1:0]     sd_a;
    logic              adc_en_a, wen_a, full_a, busy_a, overrun_a;
    logic [AW-1:0]     waddr_a;
    logic [DW-1:0]     wdata_a;
    logic [AW:0]       words_a;

    logic              arm_b, sv_b;
    logic [4*DW-1:0]   sd_b;
    logic              adc_en_b, wen_b, full_b, busy_b, overrun_b;
    logic [AW-1:0]     waddr_b;
    logic [DW-1:0]     wdata_b;
    logic [AW:0]       words_b;

    sample_capture_ctrl #(.DW(DW), .AW(AW), .NCH(1), .DEC(0)) u_dut_a (
        .clk(clk), .rst(rst), .arm(arm_a), .sample_valid(sv_a), .sample_data(sd_a),
        .adc_en(adc_en_a), .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .full(full_a),
        .busy(busy_a), .overrun(overrun_a), .words(words_a)
    );

    sample_capture_ctrl #(.DW(DW), .AW(AW), .NCH(4), .DEC(2)) u_dut_b (
        .clk(clk), .rst(rst), .arm(arm_b), .sample_valid(sv_b), .sample_data(sd_b),
        .adc_en(adc_en_b), .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .full(full_b),
        .busy(busy_b), .overrun(overrun_b), .words(words_b)
    );

    int tests = 0;
    int fails = 0;
    logic [AW+DW-1:0] qa[$];
    logic [AW+DW-1:0] qb[$];
    logic [AW+DW-1:0] ea, eb;
    int dec_m;
    int base_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors, sampling on the inactive edge.
    always @(negedge clk) begin
        if (wen_a === 1'b1) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL a_unexpected_write: observed addr %0d data %0h, expected no write",
                       waddr_a, wdata_a);
            end else begin
                ea = qa.pop_front();
                chk("a_waddr", 32'(waddr_a), 32'(ea[AW+DW-1:DW]));
                chk("a_wdata", 32'(wdata_a), 32'(ea[DW-1:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (wen_b === 1'b1) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL b_unexpected_write: observed addr %0d data %0h, expected no write",
                       waddr_b, wdata_b);
            end else begin
                eb = qb.pop_front();
                chk("b_waddr", 32'(waddr_b), 32'(eb[AW+DW-1:DW]));
                chk("b_wdata", 32'(wdata_b), 32'(eb[DW-1:0]));
            end
        end
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [DW-1:0] d);
        sv_a = 1'b1;
        sd_a = d;
        tick();
        sv_a = 1'b0;
    endtask

    // One conversion on B; serial=1 means the DUT is still serialising (overrun).
    task automatic send_b(input int n, input bit serial, input int gap, input int nwords);
        logic [4*DW-1:0] d;
        for (int k = 0; k < 4; k++) d[k*DW +: DW] = DW'(32'h1000 * (k + 1) + n);
        if (!serial && dec_m == 0) begin
            for (int k = 0; k < nwords; k++) qb.push_back({AW'(base_m + k), d[k*DW +: DW]});
            base_m += 4;
        end
        dec_m = (dec_m == 2) ? 0 : dec_m + 1;
        sv_b = 1'b1;
        sd_b = d;
        tick();
        sv_b = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic skip_b();
        sv_b = 1'b1;
        sd_b = '1;
        tick();
        sv_b = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; arm_a = 1'b0; sv_a = 1'b0; sd_a = '0;
        arm_b = 1'b0; sv_b = 1'b0; sd_b = '0; dec_m = 0; base_m = 0;
        repeat (3) tick();

        // Reset values.
        chk("rst_adc_en", 32'(adc_en_a), 0);
        chk("rst_wen", 32'(wen_a), 0);
        chk("rst_waddr", 32'(waddr_a), 0);
        chk("rst_wdata", 32'(wdata_a), 0);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_overrun", 32'(overrun_a), 0);
        chk("rst_words", 32'(words_a), 0);
        chk("rst_b_busy", 32'(busy_b), 0);

        rst = 1'b1;
        tick();
        chk("a_idle_adc_en", 32'(adc_en_a), 0);

        // A: full capture of 16 words, first sample dropped.
        arm_a = 1'b1;
        tick();
        chk("a_skip_busy", 32'(busy_a), 1);
        chk("a_skip_adc_en", 32'(adc_en_a), 1);
        for (int n = 0; n <= 16; n++) begin
            if (n > 0) qa.push_back({AW'(n - 1), DW'(n)});
            pulse_a(DW'(n));
            tick();
        end
        chk("a_full", 32'(full_a), 1);
        chk("a_full_adc_en", 32'(adc_en_a), 0);
        chk("a_full_words", 32'(words_a), 16);
        chk("a_full_waddr", 32'(waddr_a), 0);
        chk("a_full_busy", 32'(busy_a), 0);
        chk("a_full_overrun", 32'(overrun_a), 0);
        chk("a_q_drained", 32'(qa.size()), 0);

        // A: arm held high does not re-arm; samples in FULL are ignored.
        pulse_a(16'd99);
        tick();
        chk("a_hold_full", 32'(full_a), 1);
        chk("a_hold_words", 32'(words_a), 16);

        // A: re-arm, capture a few words, then reset in a write cycle.
        arm_a = 1'b0;
        tick();
        arm_a = 1'b1;
        tick();
        chk("a_rearm_full", 32'(full_a), 0);
        chk("a_rearm_words", 32'(words_a), 0);
        pulse_a(16'd0);
        tick();
        for (int n = 1; n <= 3; n++) begin
            qa.push_back({AW'(n - 1), DW'(n + 100)});
            pulse_a(DW'(n + 100));
            tick();
        end
        qa.push_back({AW'(3), DW'(104)});
        pulse_a(16'd104);
        rst = 1'b0;
        arm_a = 1'b0;
        tick();
        chk("a_mrst_adc_en", 32'(adc_en_a), 0);
        chk("a_mrst_wen", 32'(wen_a), 0);
        chk("a_mrst_waddr", 32'(waddr_a), 0);
        chk("a_mrst_wdata", 32'(wdata_a), 0);
        chk("a_mrst_words", 32'(words_a), 0);
        chk("a_mrst_busy", 32'(busy_a), 0);
        rst = 1'b1;
        tick();

        // A: arm edge coincident with sample_valid -- sample discarded, next one skipped too.
        arm_a = 1'b1;
        sv_a = 1'b1;
        sd_a = 16'd50;
        tick();
        sv_a = 1'b0;
        chk("a_coinc_busy", 32'(busy_a), 1);
        chk("a_coinc_words", 32'(words_a), 0);
        pulse_a(16'd51);
        tick();
        qa.push_back({AW'(0), DW'(52)});
        pulse_a(16'd52);
        tick();
        chk("a_coinc_words1", 32'(words_a), 1);

        // B: NCH=4, DEC=2; ten conversions, only 0,3,6,9 written; ends full.
        arm_b = 1'b1;
        tick();
        arm_b = 1'b0;
        skip_b();
        for (int n = 0; n < 10; n++) send_b(n, 1'b0, 6, 4);
        chk("b_full", 32'(full_b), 1);
        chk("b_full_words", 32'(words_b), 16);
        chk("b_full_adc_en", 32'(adc_en_b), 0);
        chk("b_no_overrun", 32'(overrun_b), 0);
        chk("b_q_drained", 32'(qb.size()), 0);

        // B: overrun from a conversion during serialisation; capture still completes.
        arm_b = 1'b1;
        tick();
        arm_b = 1'b0;
        chk("b_rearm_full", 32'(full_b), 0);
        chk("b_rearm_words", 32'(words_b), 0);
        dec_m = 0;
        base_m = 0;
        skip_b();
        send_b(0, 1'b0, 2, 4);
        send_b(1, 1'b1, 6, 4);
        chk("b_overrun_set", 32'(overrun_b), 1);
        for (int n = 2; n < 10; n++) send_b(n, 1'b0, 6, 4);
        chk("b_ovr_full", 32'(full_b), 1);
        chk("b_ovr_sticky", 32'(overrun_b), 1);
        chk("b_ovr_q_drained", 32'(qb.size()), 0);

        // B: arm edge mid-serialisation at words=5 drops the remaining channels.
        arm_b = 1'b1;
        tick();
        arm_b = 1'b0;
        chk("b_rearm_overrun", 32'(overrun_b), 0);
        dec_m = 0;
        base_m = 0;
        skip_b();
        for (int n = 0; n < 3; n++) send_b(n, 1'b0, 6, 4);
        send_b(3, 1'b0, 2, 2);
        chk("b_words_mid", 32'(words_b), 5);
        arm_b = 1'b1;
        tick();
        chk("b_abort_wen", 32'(wen_b), 0);
        chk("b_abort_waddr", 32'(waddr_b), 0);
        chk("b_abort_words", 32'(words_b), 0);
        chk("b_abort_busy", 32'(busy_b), 1);
        arm_b = 1'b0;
        dec_m = 0;
        base_m = 0;
        skip_b();
        send_b(10, 1'b0, 6, 4);
        chk("b_restart_words", 32'(words_b), 4);
        chk("b_restart_full", 32'(full_b), 0);

        repeat (3) tick();
        chk("a_final_q", 32'(qa.size()), 0);
        chk("b_final_q", 32'(qb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_capture_ctrl.md
Name: sample_capture_ctrl

Overview:
Parametrised capture sequencer between the ADC host and the sample SRAM. On an arm request it enables the ADC and discards the first (stale) sample. It then serialises NCH channel words per conversion into consecutive SRAM addresses until DEPTH words are written, and reports full. Successor to the fixed single-channel 64k-word capture loop; adds channel count, depth, decimation, overrun detection and a word counter.

Parameters:
DW, 16, sample word width (bits per channel)
AW, 16, SRAM address width; DEPTH = 2**AW words
NCH, 1, channels per conversion; power of two, 1..8, NCH <= DEPTH
DEC, 0, keep 1 of every DEC+1 conversions (0 = keep all); 8-bit range

Ports:
clk  in  1  system clock (PLL output)
rst  in  1  synchronous reset, active-low
arm  in  1  level; rising edge starts a capture (readout-done flag)
sample_valid  in  1  one-cycle pulse, new conversion on sample_data
sample_data  in  NCH*DW  channel 0 in LSBs
adc_en  out  1  enable to ADC host
wen  out  1  SRAM write strobe
waddr  out  AW  SRAM write address
wdata  out  DW  SRAM write data
full  out  1  capture complete, SRAM holds DEPTH valid words
busy  out  1  high in SKIP/CAPTURE/SERIAL
overrun  out  1  sticky: conversion arrived while serialising
words  out  AW+1  words written in current capture (0..DEPTH)

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; adc_en=0, wen=0, waddr=0, wdata=0, full=0, busy=0, overrun=0, words=0, decimation counter=0, arm edge register=0. Reset overrides all, including mid-capture.
- Arm edge: arm_q registered each cycle; edge = arm & ~arm_q. Edge in any state → SKIP, with full=0, overrun=0, words=0, waddr=0, dec counter=0; any in-flight serialisation is dropped with no further wen.
- IDLE: adc_en=0. Waits for edge.
- SKIP: adc_en=1. First sample_valid is discarded → CAPTURE.
- CAPTURE: adc_en=1. On sample_valid, if dec counter==0: latch all NCH channels → SERIAL. Dec counter increments on every sample_valid and wraps DEC→0.
- SERIAL: one word per cycle, channel 0 first. wen=1, wdata=channel k, waddr=current address for NCH consecutive cycles. waddr and words increment after each write. A sample_valid in SERIAL sets overrun and is dropped; it still advances the dec counter.
- After last channel: if words==DEPTH → FULL, else → CAPTURE.
- FULL: adc_en=0, full=1, wen=0; waddr wraps to 0, words holds DEPTH. Stays until next arm edge or reset.
- Latency: first wen is asserted the cycle after the accepted sample_valid. wen/waddr/wdata are registered.
- Boundary: DEPTH is always a multiple of NCH, so a capture never ends mid-conversion. Simultaneous arm edge and sample_valid: the edge wins and the sample is discarded. arm held high throughout does not re-arm.

Optional Feature:
CAPTURE_AVG_EN: when defined, an extra parameter AVG_LOG2 (default 2) applies. Each channel sums 2**AVG_LOG2 kept conversions in a DW+AVG_LOG2 accumulator. The sum, right-shifted by AVG_LOG2 (truncating, unsigned), is written instead of the raw sample. The accumulator clears on arm edge and after each write group; SKIP behaviour is unchanged. Undefined: raw samples are written and AVG_LOG2 is ignored.

Decomposition:
- Package sampling_pkg: state enum {IDLE, SKIP, CAPTURE, SERIAL, FULL}; localparam helpers for DEPTH and channel-index width (clog2 of NCH, min 1).
- One sub-module, chan_serializer: latches NCH*DW, emits NCH words on consecutive cycles with a done pulse, and accepts an abort. The top FSM owns the address and the counters.

Test Plan:
- NCH=1, AW=4, DEC=0: reset, arm edge, 17 sample_valid pulses with data 0..16 → sample 0 dropped; wen 16 times, addr 0..15, data 1..16; full=1 and adc_en=0 the cycle after the last write; words=16.
- NCH=4, AW=4: samples 4 cycles apart, sample_data={D,C,B,A}+n → writes A,B,C,D per conversion at consecutive addresses; full after 4 conversions.
- NCH=4, a sample_valid 2 cycles after the previous one → overrun=1, that sample never written, capture continues and completes.
- DEC=2: 10 conversions after skip → only conversions 0,3,6,9 (post-skip index) are written.
- Arm edge at words=7 mid-SERIAL → wen drops next cycle, waddr=0, words=0, the next sample is skipped, capture restarts; also rst=0 at the same point → all outputs at reset values.
- CAPTURE_AVG_EN, AVG_LOG2=2, NCH=1: kept samples 10,11,12,14 → one write of 11 (47>>2).
